// File: rtl/fifo2_pkg.sv
// Shared constants for the one/two-entry pipeline FIFO, plus the warning macro
// used when a request is dropped.
`ifndef FIFO2_PKG_SV
`define FIFO2_PKG_SV

`define FIFO_WARN(msg) $display("fifo2 warning: %m: %s", msg)

package fifo2_pkg;
    localparam int FIFO_DEPTH_1 = 1;
    localparam int FIFO_DEPTH_2 = 2;
endpackage

`endif

// File: rtl/fifo2.sv
// Depth-1/2 synchronous FIFO with registered FULL_N/EMPTY_N flags; head entry
// is always presented on D_OUT with no D_IN bypass.
module fifo2
    import fifo2_pkg::*;
#(
    parameter int width = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [width-1:0] D_OUT,
    output logic             FULL_N,
    output logic             EMPTY_N
);

    generate
        if (DEPTH != FIFO_DEPTH_1 && DEPTH != FIFO_DEPTH_2) begin : g_bad_depth
            $error("fifo2: DEPTH must be 1 or 2");
        end
    endgenerate

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic [width-1:0] data0;
    logic [width-1:0] tail;
    logic             empty_n;
    logic             full_n;
    logic             enq;
    logic             deq;
    logic             load_head;
    logic             load_tail;

    // Requests are qualified by the pre-edge flags, so illegal ones simply vanish.
    assign enq       = ENQ & full_n;
    assign deq       = DEQ & empty_n;
    assign load_head = enq & ((count == 2'd0) | ((count == 2'd1) & deq));
    assign load_tail = enq & (count == 2'd1) & ~deq;

    always_comb begin
        count_nxt = count;
        if (enq && !deq)
            count_nxt = count + 2'd1;
        else if (deq && !enq)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count   <= 2'd0;
            empty_n <= 1'b0;
            full_n  <= 1'b1;
            data0   <= '0;
        end else if (CLR) begin
            count   <= 2'd0;
            empty_n <= 1'b0;
            full_n  <= 1'b1;
        end else begin
            count   <= count_nxt;
            empty_n <= (count_nxt != 2'd0);
            full_n  <= (count_nxt != DEPTH_C);
            if (load_head)
                data0 <= D_IN;
            else if (deq && count == 2'd2)
                data0 <= tail;
        end
    end

    generate
        if (DEPTH == FIFO_DEPTH_2) begin : g_tail
            logic [width-1:0] data1;
            always_ff @(posedge CLK) begin
                if (RST)
                    data1 <= '0;
                else if (!CLR && load_tail)
                    data1 <= D_IN;
            end
            assign tail = data1;
        end else begin : g_no_tail
            assign tail = '0;
        end
    endgenerate

    assign D_OUT   = data0;
    assign FULL_N  = full_n;
    assign EMPTY_N = empty_n;

`ifndef SYNTHESIS
`ifndef FIFO_NO_WARN
    always @(posedge CLK) begin
        if (!RST && !CLR) begin
            if (ENQ && !full_n)
                `FIFO_WARN("ENQ while full, request dropped");
            if (DEQ && !empty_n)
                `FIFO_WARN("DEQ while empty, request dropped");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_fifo2.sv
// Scoreboard bench for fifo2: one DEPTH=2 and one DEPTH=1 instance share a clock;
// expected contents live in queues updated as stimulus is applied.
module tb_fifo2;

    logic       clk = 1'b0;
    logic       rst, clr2, clr1;
    logic       enq2, deq2, enq1, deq1;
    logic [7:0] din2, din1, dout2, dout1;
    logic       full_n2, empty_n2, full_n1, empty_n1;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q2[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    fifo2 #(.width(8), .DEPTH(2)) u_fifo2 (
        .CLK(clk), .RST(rst), .D_IN(din2), .ENQ(enq2), .DEQ(deq2), .CLR(clr2),
        .D_OUT(dout2), .FULL_N(full_n2), .EMPTY_N(empty_n2)
    );

    fifo2 #(.width(8), .DEPTH(1)) u_fifo1 (
        .CLK(clk), .RST(rst), .D_IN(din1), .ENQ(enq1), .DEQ(deq1), .CLR(clr1),
        .D_OUT(dout1), .FULL_N(full_n1), .EMPTY_N(empty_n1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: pop before push so enq+deq with one entry replaces it.
    task automatic model(input logic r, input logic c, input logic e, input logic d,
                         input logic [7:0] din, input int depth, inout logic [7:0] q[$]);
        logic ok_e, ok_d;
        if (r || c) begin
            q.delete();
        end else begin
            ok_e = e && (q.size() != depth);
            ok_d = d && (q.size() != 0);
            if (ok_d) void'(q.pop_front());
            if (ok_e) q.push_back(din);
        end
    endtask

    task automatic check_all();
        chk("empty_n2", empty_n2, 8'(q2.size() != 0));
        chk("full_n2",  full_n2,  8'(q2.size() != 2));
        if (q2.size() != 0) chk("dout2", dout2, q2[0]);
        chk("empty_n1", empty_n1, 8'(q1.size() != 0));
        chk("full_n1",  full_n1,  8'(q1.size() != 1));
        if (q1.size() != 0) chk("dout1", dout1, q1[0]);
    endtask

    task automatic cyc(input logic e2, input logic d2, input logic [7:0] i2,
                       input logic e1, input logic d1, input logic [7:0] i1,
                       input logic c2, input logic c1, input logic r);
        enq2 = e2; deq2 = d2; din2 = i2; clr2 = c2;
        enq1 = e1; deq1 = d1; din1 = i1; clr1 = c1;
        rst  = r;
        @(posedge clk);
        model(r, c2, e2, d2, i2, 2, q2);
        model(r, c1, e1, d1, i1, 1, q1);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr2 = 1'b0; clr1 = 1'b0;
        enq2 = 1'b0; deq2 = 1'b0; din2 = '0;
        enq1 = 1'b0; deq1 = 1'b0; din1 = '0;

        // reset
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        chk("rst_dout2", dout2, 8'h00);
        chk("rst_dout1", dout1, 8'h00);
        chk("rst_full_n2", full_n2, 8'h01);
        cyc(0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        chk("deq_empty_empty_n2", empty_n2, 8'h00);
        chk("deq_empty_full_n1", full_n1, 8'h01);

        // depth 2 fill and drain
        cyc(1, 0, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h22, 0, 0, 8'h00, 0, 0, 0);
        chk("fill_dout2", dout2, 8'h11);
        chk("fill_full_n2", full_n2, 8'h00);
        cyc(1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        chk("drain_dout2", dout2, 8'h22);
        cyc(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        chk("drain_empty_n2", empty_n2, 8'h00);

        // simultaneous enq+deq
        cyc(1, 0, 8'hA5, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
        chk("sim1_dout2", dout2, 8'h5A);
        chk("sim1_full_n2", full_n2, 8'h01);
        cyc(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h01, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h02, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h03, 0, 0, 8'h00, 0, 0, 0);
        chk("sim2_dout2", dout2, 8'h02);
        chk("sim2_full_n2", full_n2, 8'h01);
        cyc(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        chk("sim2_lost_empty_n2", empty_n2, 8'h00);

        // depth 1
        cyc(0, 0, 8'h00, 1, 0, 8'hC3, 0, 0, 0);
        chk("d1_dout1", dout1, 8'hC3);
        chk("d1_full_n1", full_n1, 8'h00);
        cyc(0, 0, 8'h00, 1, 1, 8'h3C, 0, 0, 0);
        chk("d1_drop_empty_n1", empty_n1, 8'h00);
        cyc(0, 0, 8'h00, 1, 0, 8'h3C, 0, 0, 0);
        chk("d1_dout1_3c", dout1, 8'h3C);

        // clear and reset priority
        cyc(1, 0, 8'h44, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h55, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h66, 1, 1, 8'h77, 1, 1, 0);
        chk("clr_empty_n2", empty_n2, 8'h00);
        chk("clr_full_n2", full_n2, 8'h01);
        chk("clr_empty_n1", empty_n1, 8'h00);
        cyc(1, 0, 8'h88, 1, 0, 8'h99, 0, 0, 1);
        chk("rst_enq_empty_n2", empty_n2, 8'h00);
        chk("rst_enq_empty_n1", empty_n1, 8'h00);

        // random traffic on both depths
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                $urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
